// File: rtl/gayle_sector_xfer.sv
// Sector transfer engine between the Gayle IDE sector FIFO and the HPS word channel.
// Optional HPS inactivity timeout: define GAYLE_XFER_TIMEOUT_EN.
module gayle_sector_xfer #(
    parameter int unsigned SECTOR_WORDS   = 256,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic        start,
    input  logic        dir,
    input  logic [7:0]  sec_cnt,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        drq,
    output logic        err,
    output logic [8:0]  sectors_left,
    output logic        fifo_wr,
    output logic [15:0] fifo_din,
    output logic        fifo_rd,
    input  logic [15:0] fifo_dout,
    input  logic        fifo_full,
    input  logic        fifo_empty,
    input  logic        fifo_last_in,
    input  logic        fifo_last_out,
    output logic        hps_req,
    input  logic        hps_ack,
    input  logic [15:0] hps_din,
    output logic [15:0] hps_dout
);

    localparam int unsigned CntW = $clog2(SECTOR_WORDS);
    localparam logic [CntW-1:0] LastWord = CntW'(SECTOR_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle, StD2hFill, StD2hDrain, StH2dWait, StH2dPres, StH2dGap, StFinish
    } state_e;

    state_e          state_q, state_d;
    logic [8:0]      sectors_left_q, sectors_left_d;
    logic [CntW-1:0] word_cnt_q, word_cnt_d;
    logic            err_q, err_d;
    logic            last_word;
    logic            strobe_ok;
    logic            timeout;

    assign last_word = (word_cnt_q == LastWord);
    // Strobes only on real enabled cycles, and never on an abort or reset cycle.
    assign strobe_ok = clk7_en & ~abort & ~reset;

`ifdef GAYLE_XFER_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
    logic [ToW-1:0] to_q, to_d;

    always_comb begin
        to_d    = '0;
        timeout = 1'b0;
        if ((state_q == StD2hFill || state_q == StH2dPres) && !hps_ack) begin
            to_d    = to_q + 1'b1;
            timeout = (to_d == ToW'(TIMEOUT_CYCLES));
        end
    end

    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) to_q <= '0;
            else       to_q <= to_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                state_q        <= StIdle;
                sectors_left_q <= '0;
                word_cnt_q     <= '0;
                err_q          <= 1'b0;
            end else begin
                state_q        <= state_d;
                sectors_left_q <= sectors_left_d;
                word_cnt_q     <= word_cnt_d;
                err_q          <= err_d;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        sectors_left_d = sectors_left_q;
        word_cnt_d     = word_cnt_q;
        err_d          = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sectors_left_d = (sec_cnt == 8'd0) ? 9'd256 : {1'b0, sec_cnt};
                    err_d          = 1'b0;
                    word_cnt_d     = '0;
                    state_d        = dir ? StH2dWait : StD2hFill;
                end
            end
            StD2hFill: begin
                if (hps_ack) begin
                    if (fifo_last_in != last_word) err_d = 1'b1;
                    if (last_word) begin
                        word_cnt_d = '0;
                        state_d    = StD2hDrain;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            StD2hDrain: begin
                if (fifo_empty) begin
                    sectors_left_d = sectors_left_q - 9'd1;
                    state_d        = (sectors_left_q == 9'd1) ? StFinish : StD2hFill;
                end
            end
            StH2dWait: begin
                if (fifo_full) state_d = StH2dPres;
            end
            StH2dPres: begin
                if (hps_ack) begin
                    if (fifo_last_out != last_word) err_d = 1'b1;
                    state_d = StH2dGap;
                end
            end
            StH2dGap: begin
                if (last_word) begin
                    sectors_left_d = sectors_left_q - 9'd1;
                    word_cnt_d     = '0;
                    state_d        = (sectors_left_q == 9'd1) ? StFinish : StH2dWait;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    state_d    = StH2dPres;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        // Abort outranks any ack taken this cycle, including its error check.
        if (state_q != StIdle && abort) begin
            state_d        = StIdle;
            sectors_left_d = '0;
            word_cnt_d     = '0;
            err_d          = err_q;
        end else if (timeout) begin
            state_d        = StIdle;
            sectors_left_d = '0;
            word_cnt_d     = '0;
            err_d          = 1'b1;
        end
    end

    always_comb begin
        busy     = (state_q != StIdle);
        done     = (state_q == StFinish);
        drq      = (state_q == StD2hDrain) || (state_q == StH2dWait);
        hps_req  = (state_q == StD2hFill) || (state_q == StH2dPres);
        fifo_wr  = (state_q == StD2hFill) && hps_ack && strobe_ok;
        fifo_rd  = (state_q == StH2dPres) && hps_ack && strobe_ok;
        fifo_din = hps_din;
        hps_dout = (state_q == StH2dPres) ? fifo_dout : 16'h0000;
    end

    assign err          = err_q;
    assign sectors_left = sectors_left_q;

endmodule

// File: tb/tb_gayle_sector_xfer.sv
// Scoreboard bench for gayle_sector_xfer: stimulus pushes expected FIFO/HPS words,
// a negedge monitor pops and compares them whenever a strobe fires.
module tb_gayle_sector_xfer;

    logic        clk = 1'b0;
    logic        reset, clk7_en, start, dir, abort;
    logic [7:0]  sec_cnt;
    logic        busy, done, drq, err;
    logic [8:0]  sectors_left;
    logic        fifo_wr, fifo_rd;
    logic [15:0] fifo_din, fifo_dout;
    logic        fifo_full, fifo_empty, fifo_last_in, fifo_last_out;
    logic        hps_req, hps_ack;
    logic [15:0] hps_din, hps_dout;

    gayle_sector_xfer #(
        .SECTOR_WORDS   (256),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clk7_en       (clk7_en),
        .start         (start),
        .dir           (dir),
        .sec_cnt       (sec_cnt),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .drq           (drq),
        .err           (err),
        .sectors_left  (sectors_left),
        .fifo_wr       (fifo_wr),
        .fifo_din      (fifo_din),
        .fifo_rd       (fifo_rd),
        .fifo_dout     (fifo_dout),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .fifo_last_in  (fifo_last_in),
        .fifo_last_out (fifo_last_out),
        .hps_req       (hps_req),
        .hps_ack       (hps_ack),
        .hps_din       (hps_din),
        .hps_dout      (hps_dout)
    );

    always #5 clk = ~clk;

    // Sector FIFO read side model: registered data, pointer advances on each read strobe.
    logic [15:0] mem [0:1023];
    logic [9:0]  rd_ptr = '0;
    always @(posedge clk) if (fifo_rd && clk7_en) rd_ptr <= rd_ptr + 10'd1;
    assign fifo_dout     = mem[rd_ptr];
    assign fifo_last_out = (rd_ptr[7:0] == 8'hFF);

    int errors = 0, checks = 0;
    int wr_count = 0, rd_count = 0, done_count = 0, drq_req_both = 0;
    logic [15:0] exp_wr_q[$];
    logic [15:0] exp_rd_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (clk7_en) begin
            if (fifo_wr) begin
                wr_count++;
                if (exp_wr_q.size() == 0) check("fifo_wr_expected", exp_wr_q.size(), 1);
                else check("fifo_din", fifo_din, exp_wr_q.pop_front());
            end
            if (fifo_rd) begin
                rd_count++;
                if (exp_rd_q.size() == 0) check("fifo_rd_expected", exp_rd_q.size(), 1);
                else check("hps_dout", hps_dout, exp_rd_q.pop_front());
            end
            if (done) done_count++;
            if (drq && hps_req) drq_req_both++;
        end else begin
            check("strobe_gated", {fifo_wr, fifo_rd}, 0);
        end
        check("strobe_excl", fifo_wr & fifo_rd, 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic d, input logic [7:0] n);
        start   = 1'b1;
        dir     = d;
        sec_cnt = n;
        tick();
        start = 1'b0;
    endtask

    task automatic d2h_sector(input logic inject);
        int d0, w0;
        d0 = done_count;
        w0 = wr_count;
        start_cmd(1'b0, 8'd1);
        check("d2h_sl_start", sectors_left, 1);
        check("d2h_req_fill", hps_req, 1);
        for (int i = 0; i < 256; i++) begin
            hps_ack      = 1'b1;
            hps_din      = 16'(i);
            fifo_last_in = (i == 255) || (inject && i == 100);
            exp_wr_q.push_back(16'(i));
            tick();
        end
        hps_ack      = 1'b0;
        fifo_last_in = 1'b0;
        check("d2h_drq_drain", drq, 1);
        check("d2h_req_drain", hps_req, 0);
        check("d2h_sl_drain", sectors_left, 1);
        tick();
        tick();
        check("d2h_drq_hold", drq, 1);
        fifo_empty = 1'b1;
        tick();
        fifo_empty = 1'b0;
        check("d2h_done", done, 1);
        check("d2h_sl_end", sectors_left, 0);
        check("d2h_drq_finish", drq, 0);
        tick();
        check("d2h_idle", busy, 0);
        check("d2h_done_pulse", done, 0);
        check("d2h_done_count", done_count - d0, 1);
        check("d2h_wr_count", wr_count - w0, 256);
        check("d2h_err", err, inject);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0, w0, r0, waited, base;
        reset = 1'b1; clk7_en = 1'b1; start = 1'b0; dir = 1'b0; sec_cnt = 8'd0;
        abort = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b0; fifo_last_in = 1'b0;
        hps_ack = 1'b0; hps_din = 16'h0000;
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 37 + 16'h5A00);
        repeat (3) tick();
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_drq", drq, 0);
        check("rst_err", err, 0);
        check("rst_sl", sectors_left, 0);
        check("rst_req", hps_req, 0);

        // Reset in the middle of a fill abandons the command.
        d0 = done_count;
        start_cmd(1'b0, 8'd3);
        for (int i = 0; i < 5; i++) begin
            hps_ack = 1'b1;
            hps_din = 16'(16'h1000 + i);
            exp_wr_q.push_back(16'(16'h1000 + i));
            tick();
        end
        hps_ack = 1'b0;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_sl", sectors_left, 0);
        check("midrst_req", hps_req, 0);
        check("midrst_nodone", done_count - d0, 0);
        check("midrst_words", exp_wr_q.size(), 0);

        // sec_cnt of zero means 256 sectors.
        start_cmd(1'b0, 8'd0);
        check("sc0_sl", sectors_left, 256);
        check("sc0_busy", busy, 1);
        check("sc0_drq", drq, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("sc0_abort_busy", busy, 0);
        check("sc0_abort_sl", sectors_left, 0);

        d2h_sector(1'b0);
        d2h_sector(1'b1);

        // Amiga-to-device, two sectors straight out of a full FIFO.
        base = int'(rd_ptr);
        for (int i = 0; i < 512; i++) exp_rd_q.push_back(mem[base + i]);
        fifo_full = 1'b1;
        d0 = done_count;
        r0 = rd_count;
        start_cmd(1'b1, 8'd2);
        check("h2d_drq_wait", drq, 1);
        check("h2d_err_cleared", err, 0);
        check("h2d_sl_start", sectors_left, 2);
        for (int w = 0; w < 512; w++) begin
            waited = 0;
            while (!hps_req && waited < 8) begin
                tick();
                waited++;
            end
            if (!hps_req) begin
                check("h2d_req_seen", hps_req, 1);
                break;
            end
            hps_ack = 1'b1;
            tick();
            hps_ack = 1'b0;
            check("h2d_gap", hps_req, 0);
        end
        waited = 0;
        while (!done && waited < 8) begin
            tick();
            waited++;
        end
        check("h2d_done", done, 1);
        check("h2d_sl_end", sectors_left, 0);
        tick();
        check("h2d_idle", busy, 0);
        check("h2d_rd_count", rd_count - r0, 512);
        check("h2d_done_count", done_count - d0, 1);
        check("h2d_err", err, 0);
        check("h2d_all_words", exp_rd_q.size(), 0);

        // Abort together with an ack while a word is presented.
        d0 = done_count;
        r0 = rd_count;
        start_cmd(1'b1, 8'd1);
        waited = 0;
        while (!hps_req && waited < 8) begin
            tick();
            waited++;
        end
        check("abort_in_pres", hps_req, 1);
        hps_ack = 1'b1;
        abort   = 1'b1;
        #1;
        check("abort_no_rd", fifo_rd, 0);
        tick();
        hps_ack   = 1'b0;
        abort     = 1'b0;
        fifo_full = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sl", sectors_left, 0);
        check("abort_rd_count", rd_count - r0, 0);
        check("abort_done_count", done_count - d0, 0);

        // Strobes and state hold while the clock enable is low.
        w0 = wr_count;
        start_cmd(1'b0, 8'd1);
        clk7_en = 1'b0;
        hps_ack = 1'b1;
        hps_din = 16'hBEEF;
        repeat (3) tick();
        check("gate_req_held", hps_req, 1);
        check("gate_no_wr", wr_count - w0, 0);
        hps_ack = 1'b0;
        clk7_en = 1'b1;
        abort   = 1'b1;
        tick();
        abort = 1'b0;
        check("gate_abort_busy", busy, 0);

        // HPS never acks.
        d0 = done_count;
        start_cmd(1'b0, 8'd1);
`ifdef GAYLE_XFER_TIMEOUT_EN
        repeat (15) tick();
        check("to_busy_before", busy, 1);
        tick();
        check("to_busy_after", busy, 0);
        check("to_err", err, 1);
        check("to_no_done", done_count - d0, 0);
`else
        repeat (40) tick();
        check("noto_busy", busy, 1);
        check("noto_req", hps_req, 1);
        check("noto_err", err, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("noto_abort_busy", busy, 0);
        check("noto_no_done", done_count - d0, 0);
`endif
        check("drq_never_with_req", drq_req_both, 0);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gayle_sector_xfer.md
Name: gayle_sector_xfer

Overview:
- Controller-side transfer engine for the Gayle IDE sector FIFO. It moves 256-word sectors between the FIFO and the HPS word channel.
- Device-to-Amiga (dir=0): accepts HPS words and writes them into the FIFO, then raises DRQ for the Amiga.
- Amiga-to-device (dir=1): waits until the Amiga has written a full sector, then streams it out to the HPS.
- Counts sectors for multi-sector commands and reports completion and errors.

Parameters:
- SECTOR_WORDS, 256, words per sector; the sector word counter is log2(SECTOR_WORDS) bits wide.
- TIMEOUT_CYCLES, 65535, clk7_en cycles of HPS inactivity before abort. Used only with GAYLE_XFER_TIMEOUT_EN.

Ports:
- clk  in  1  bus clock
- reset  in  1  synchronous, active-high
- clk7_en  in  1  clock enable; all state advances only on clk&clk7_en
- start  in  1  begin a command (sampled in IDLE only)
- dir  in  1  0=device->Amiga (HPS writes FIFO), 1=Amiga->device (HPS reads FIFO); latched at start
- sec_cnt  in  8  sector count; 0 means 256; latched at start
- abort  in  1  cancel the transfer
- busy  out  1  state != IDLE
- done  out  1  one enabled-cycle pulse at command completion
- drq  out  1  FIFO ready for Amiga side
- err  out  1  sticky error; cleared by start
- sectors_left  out  9  remaining sectors
- fifo_wr  out  1  FIFO write strobe
- fifo_din  out  16  FIFO write data
- fifo_rd  out  1  FIFO read strobe
- fifo_dout  in  16  FIFO registered read data
- fifo_full  in  1  at least one sector in the FIFO
- fifo_empty  in  1  FIFO empty
- fifo_last_in  in  1  sector's last word being written
- fifo_last_out  in  1  sector's last word being read
- hps_req  out  1  word wanted (dir=0) or word offered (dir=1)
- hps_ack  in  1  HPS accepts or supplies the word this enabled cycle
- hps_din  in  16  word from HPS
- hps_dout  out  16  word to HPS

Behaviour:
- Reset, sampled on enabled cycles:
  - State goes to IDLE.
  - busy, done, drq, err, fifo_wr, fifo_rd and hps_req are all 0; sectors_left=0; word counter=0.
  - Reset mid-transfer abandons the transfer with no done pulse.
- States: IDLE, D2H_FILL, D2H_DRAIN, H2D_WAIT, H2D_PRES, H2D_GAP, FINISH.
- IDLE:
  - On start: sectors_left = (sec_cnt==0) ? 256 : sec_cnt; err=0; word counter=0.
  - Next state is D2H_FILL if dir=0, otherwise H2D_WAIT.
- D2H_FILL:
  - hps_req=1.
  - fifo_wr = hps_ack (combinational, same cycle); fifo_din = hps_din.
  - Each ack increments the word counter.
  - On the ack of word SECTOR_WORDS-1: go to D2H_DRAIN and reset the counter.
  - If fifo_last_in != (counter==SECTOR_WORDS-1) on any ack, set err (transfer continues).
- D2H_DRAIN:
  - drq=1; hps_req=0.
  - When fifo_empty=1: decrement sectors_left.
  - If the new value is 0, go to FINISH; otherwise go to D2H_FILL.
- H2D_WAIT:
  - drq=1.
  - When fifo_full=1: go to H2D_PRES.
- H2D_PRES:
  - hps_req=1; hps_dout = fifo_dout.
  - On hps_ack: fifo_rd=1 and go to H2D_GAP.
  - If fifo_last_out != (counter==SECTOR_WORDS-1) at ack, set err.
- H2D_GAP:
  - Exactly one enabled cycle with hps_req=0, covering the FIFO's 1-cycle registered read latency.
  - If the previous word was SECTOR_WORDS-1: decrement sectors_left, reset the counter, and go to FINISH if sectors_left is now 0, otherwise H2D_WAIT.
  - Otherwise increment the counter and go to H2D_PRES.
- FINISH: done=1 for one enabled cycle, then go to IDLE.
- Strobes:
  - fifo_rd and fifo_wr are never both 1.
  - Neither strobe asserts on a cycle without clk7_en.
- abort in any non-IDLE state:
  - Go to IDLE next enabled cycle; sectors_left=0; no done pulse.
  - Strobes are suppressed on the abort cycle.
  - abort has priority over hps_ack.
- start while busy is ignored.

Optional Feature:
- Macro: GAYLE_XFER_TIMEOUT_EN.
- When defined:
  - A counter runs in D2H_FILL and H2D_PRES; it resets on hps_ack or on a state change.
  - Reaching TIMEOUT_CYCLES sets err and returns to IDLE with no done pulse.
- When undefined: no counter; the engine waits indefinitely.

Test Plan:
- Reset mid-transfer: reset=1 for one enabled cycle during D2H_FILL -> next cycle busy=0, sectors_left=0, hps_req=0, no done pulse.
- dir=0, sec_cnt=1, HPS acks 256 words 0x0000..0x00FF, fifo_empty asserts after the Amiga drains -> 256 fifo_wr pulses with matching data; drq high only in DRAIN; done pulses once; sectors_left 1->0.
- dir=1, sec_cnt=2, FIFO preloaded with 512 words, fifo_full=1 -> hps_dout sequence equals FIFO contents; one gap cycle per word; 512 fifo_rd pulses; done after the second sector.
- sec_cnt=0 -> sectors_left=256 after start.
- abort asserted during H2D_PRES together with hps_ack -> no fifo_rd, IDLE next cycle, done=0.
- fifo_last_in asserted at word 100 in D2H_FILL -> err=1; transfer still completes. With GAYLE_XFER_TIMEOUT_EN and TIMEOUT_CYCLES=16 and no ack: err=1 and busy=0 after 16 enabled cycles.
